// File: rtl/assoc_cache_wb.sv
// Set-associative write-back, write-allocate data cache with true-LRU replacement,
// a clocked miss/flush FSM and saturating hit/miss counters.
module assoc_cache_wb #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned WORD_W         = 16,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned SETS           = 2,
    parameter int unsigned WAYS           = 4,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               read,
    input  logic                               write,
    input  logic [ADDR_W-1:0]                  address,
    input  logic [WORD_W-1:0]                  inputData,
    output logic [WORD_W-1:0]                  readData,
    output logic                               ready,
    input  logic                               flush,
    output logic                               flush_busy,
    output logic [ADDR_W-1:0]                  addressM,
    output logic                               readM,
    output logic                               writeM,
    output logic [WORD_W*WORDS_PER_LINE-1:0]   dataM_out,
    input  logic [WORD_W*WORDS_PER_LINE-1:0]   dataM_in,
    input  logic                               memory_ack,
    output logic [CNT_W-1:0]                   hit_count,
    output logic [CNT_W-1:0]                   miss_count
);

    localparam int unsigned OFF      = $clog2(WORDS_PER_LINE);
    localparam int unsigned SET_BITS = $clog2(SETS);
    localparam int unsigned IDX_W    = (SET_BITS > 0) ? SET_BITS : 1;
    localparam int unsigned TAG_W    = ADDR_W - OFF - SET_BITS;
    localparam int unsigned WAY_W    = $clog2(WAYS);

    typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

    typedef enum logic [2:0] {StIdle, StWb, StFill, StFlushScan, StFlushWb} state_e;

    state_e            state_q;
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    line_t             data_q  [SETS][WAYS];
    logic [WAY_W-1:0]  rank_q  [SETS][WAYS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];

    logic [TAG_W-1:0]  miss_tag_q;
    logic [IDX_W-1:0]  miss_idx_q;
    logic [WAY_W-1:0]  victim_q;
    logic [IDX_W-1:0]  scan_set_q;
    logic [WAY_W-1:0]  scan_way_q;
    logic              refill_q;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF-1:0]    req_off;
    logic              hit_any;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim;
    line_t             hit_line;
    logic              scan_last;

    assign req_tag = address[ADDR_W-1 -: TAG_W];
    assign req_off = address[OFF-1:0];

    generate
        if (SET_BITS == 0) begin : g_one_set
            assign req_idx = '0;
        end else begin : g_sets
            assign req_idx = address[OFF +: SET_BITS];
        end
    endgenerate

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [IDX_W-1:0] idx);
        logic [ADDR_W-1:0] a;
        a = '0;
        a[ADDR_W-1 -: TAG_W] = tag;
        a = a | (ADDR_W'(idx) << OFF);
        return a;
    endfunction

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Invalid ways take precedence over the LRU way; descending loops leave the lowest index.
    always_comb begin
        victim = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (rank_q[req_idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) victim = WAY_W'(w);
        end
    end

    assign hit_line  = data_q[req_idx][hit_way];
    assign ready     = (state_q == StIdle) && (read || write) && hit_any;
    assign readData  = (ready && read) ? hit_line[req_off] : '0;
    assign scan_last = (scan_set_q == IDX_W'(SETS - 1)) && (scan_way_q == WAY_W'(WAYS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            readM      <= 1'b0;
            writeM     <= 1'b0;
            addressM   <= '0;
            dataM_out  <= '0;
            flush_busy <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
            victim_q   <= '0;
            scan_set_q <= '0;
            scan_way_q <= '0;
            refill_q   <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    data_q[s][w] <= '0;
                    rank_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    refill_q <= 1'b0;
                    if (ready) begin
                        // The hit that completes a refill was already counted as a miss.
                        if (!refill_q && (hit_count != '1)) hit_count <= hit_count + 1'b1;
                        if (write) begin
                            data_q[req_idx][hit_way][req_off] <= inputData;
                            dirty_q[req_idx][hit_way]         <= 1'b1;
                        end
                        for (int w = 0; w < WAYS; w++) begin
                            if (WAY_W'(w) == hit_way) begin
                                rank_q[req_idx][w] <= '0;
                            end else if (rank_q[req_idx][w] < rank_q[req_idx][hit_way]) begin
                                rank_q[req_idx][w] <= rank_q[req_idx][w] + 1'b1;
                            end
                        end
                    end else if (flush) begin
                        flush_busy <= 1'b1;
                        scan_set_q <= '0;
                        scan_way_q <= '0;
                        state_q    <= StFlushScan;
                    end else if (read || write) begin
                        if (miss_count != '1) miss_count <= miss_count + 1'b1;
                        miss_tag_q <= req_tag;
                        miss_idx_q <= req_idx;
                        victim_q   <= victim;
                        if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
                            writeM    <= 1'b1;
                            addressM  <= line_addr(tag_q[req_idx][victim], req_idx);
                            dataM_out <= data_q[req_idx][victim];
                            state_q   <= StWb;
                        end else begin
                            readM    <= 1'b1;
                            addressM <= line_addr(req_tag, req_idx);
                            state_q  <= StFill;
                        end
                    end
                end
                StWb: begin
                    if (memory_ack) begin
                        writeM                        <= 1'b0;
                        dirty_q[miss_idx_q][victim_q] <= 1'b0;
                        readM                         <= 1'b1;
                        addressM                      <= line_addr(miss_tag_q, miss_idx_q);
                        state_q                       <= StFill;
                    end
                end
                StFill: begin
                    if (memory_ack) begin
                        readM                         <= 1'b0;
                        data_q[miss_idx_q][victim_q]  <= dataM_in;
                        tag_q[miss_idx_q][victim_q]   <= miss_tag_q;
                        valid_q[miss_idx_q][victim_q] <= 1'b1;
                        dirty_q[miss_idx_q][victim_q] <= 1'b0;
                        refill_q                      <= 1'b1;
                        state_q                       <= StIdle;
                    end
                end
                StFlushScan: begin
                    if (valid_q[scan_set_q][scan_way_q] && dirty_q[scan_set_q][scan_way_q]) begin
                        writeM    <= 1'b1;
                        addressM  <= line_addr(tag_q[scan_set_q][scan_way_q], scan_set_q);
                        dataM_out <= data_q[scan_set_q][scan_way_q];
                        state_q   <= StFlushWb;
                    end else if (scan_last) begin
                        for (int s = 0; s < SETS; s++) begin
                            valid_q[s] <= '0;
                            dirty_q[s] <= '0;
                            for (int w = 0; w < WAYS; w++) rank_q[s][w] <= WAY_W'(w);
                        end
                        flush_busy <= 1'b0;
                        state_q    <= StIdle;
                    end else if (scan_way_q == WAY_W'(WAYS - 1)) begin
                        scan_way_q <= '0;
                        scan_set_q <= scan_set_q + 1'b1;
                    end else begin
                        scan_way_q <= scan_way_q + 1'b1;
                    end
                end
                StFlushWb: begin
                    // Rescan the same entry; it is now clean, so the scan simply advances.
                    if (memory_ack) begin
                        writeM                            <= 1'b0;
                        dirty_q[scan_set_q][scan_way_q]   <= 1'b0;
                        state_q                           <= StFlushScan;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_assoc_cache_wb.sv
// Directed self-checking bench for assoc_cache_wb: hits, misses, write-back, LRU, flush,
// asynchronous reset during write-back and counter saturation (CNT_W=4 shadow instance).
module tb_assoc_cache_wb;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic        flush = 1'b0;
    logic        memory_ack = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] inputData = '0;
    logic [63:0] dataM_in = '0;

    logic [15:0] readData, addressM, hit_count, miss_count;
    logic        ready, flush_busy, readM, writeM;
    logic [63:0] dataM_out;

    logic [15:0] c4_readData, c4_addressM;
    logic [3:0]  c4_hit_count, c4_miss_count;
    logic        c4_ready, c4_flush_busy, c4_readM, c4_writeM;
    logic [63:0] c4_dataM_out;

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [63:0] d;
        bit          busy;
    } txn_t;

    txn_t        txlog[$];
    logic [63:0] mem [0:16383];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_hit = 0;
    int          exp_miss = 0;

    always #5 clk = ~clk;

    assoc_cache_wb dut (
        .clk(clk), .reset_n(reset_n), .read(read), .write(write), .address(address),
        .inputData(inputData), .readData(readData), .ready(ready), .flush(flush),
        .flush_busy(flush_busy), .addressM(addressM), .readM(readM), .writeM(writeM),
        .dataM_out(dataM_out), .dataM_in(dataM_in), .memory_ack(memory_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    assoc_cache_wb #(.CNT_W(4)) dut_c4 (
        .clk(clk), .reset_n(reset_n), .read(read), .write(write), .address(address),
        .inputData(inputData), .readData(c4_readData), .ready(c4_ready), .flush(flush),
        .flush_busy(c4_flush_busy), .addressM(c4_addressM), .readM(c4_readM),
        .writeM(c4_writeM), .dataM_out(c4_dataM_out), .dataM_in(dataM_in),
        .memory_ack(memory_ack), .hit_count(c4_hit_count), .miss_count(c4_miss_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Initial memory contents: word k of line L is {k, L[11:0]}.
    function automatic logic [15:0] init_word(input logic [15:0] a);
        logic [11:0] ln;
        ln = 12'(a >> 2);
        return {2'b00, a[1:0], ln};
    endfunction

    // Line memory: acks one cycle-pulse after ack_delay visible request cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (memory_ack) begin
                memory_ack = 1'b0;
            end else if (readM || writeM) begin
                if (wait_cnt < ack_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    if (writeM) begin
                        txlog.push_back('{wr: 1'b1, a: addressM, d: dataM_out, busy: flush_busy});
                        mem[addressM >> 2] = dataM_out;
                    end else begin
                        txlog.push_back('{wr: 1'b0, a: addressM, d: '0, busy: flush_busy});
                        dataM_in = mem[addressM >> 2];
                    end
                    memory_ack = 1'b1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic access(input string tag, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input bit exp_is_hit,
                          input logic [15:0] exp_rd);
        int cyc;
        cyc = 0;
        read = !w;
        write = w;
        address = a;
        inputData = d;
        @(negedge clk);
        while (!ready && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check_eq({tag, "_ready"}, 64'(ready), 64'(1));
        check_eq({tag, "_hit"}, 64'(cyc == 0), 64'(exp_is_hit));
        check_eq({tag, "_c4_ready"}, 64'(c4_ready), 64'(1));
        if (!w) begin
            check_eq({tag, "_data"}, 64'(readData), 64'(exp_rd));
            check_eq({tag, "_c4_data"}, 64'(c4_readData), 64'(exp_rd));
        end
        if (exp_is_hit) exp_hit++;
        else exp_miss++;
        @(posedge clk);
        #1;
        read = 1'b0;
        write = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        check_eq({tag, "_hits"}, 64'(hit_count), 64'(exp_hit));
        check_eq({tag, "_misses"}, 64'(miss_count), 64'(exp_miss));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        int cyc;
        for (int l = 0; l < 16384; l++) begin
            mem[l] = {init_word(16'(l * 4 + 3)), init_word(16'(l * 4 + 2)),
                      init_word(16'(l * 4 + 1)), init_word(16'(l * 4))};
        end
        mem[4] = 64'h4444_3333_2222_1111;

        // Reset state
        #12;
        check_eq("rst_ready", 64'(ready), 64'(0));
        check_eq("rst_readM", 64'(readM), 64'(0));
        check_eq("rst_writeM", 64'(writeM), 64'(0));
        check_eq("rst_busy", 64'(flush_busy), 64'(0));
        check_eq("rst_addrM", 64'(addressM), 64'(0));
        check_eq("rst_dataM", dataM_out, 64'(0));
        check_eq("rst_rdata", 64'(readData), 64'(0));
        check_eq("rst_hits", 64'(hit_count), 64'(0));
        check_eq("rst_misses", 64'(miss_count), 64'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // First miss, cycle by cycle
        read = 1'b1;
        address = 16'h0010;
        @(negedge clk);
        check_eq("m1_ready0", 64'(ready), 64'(0));
        @(negedge clk);
        check_eq("m1_readM", 64'(readM), 64'(1));
        check_eq("m1_writeM", 64'(writeM), 64'(0));
        check_eq("m1_addrM", 64'(addressM), 64'h0010);
        check_eq("m1_ready1", 64'(ready), 64'(0));
        @(negedge clk);
        check_eq("m1_ready2", 64'(ready), 64'(1));
        check_eq("m1_data", 64'(readData), 64'h1111);
        @(posedge clk);
        #1;
        read = 1'b0;
        exp_miss = 1;
        access("rd13", 1'b0, 16'h0013, '0, 1'b1, 16'h4444);
        check_counts("cnt1");

        // Dirty line becomes LRU and is written back before the refill
        access("wr11", 1'b1, 16'h0011, 16'hBEEF, 1'b1, '0);
        txlog.delete();
        access("f18", 1'b0, 16'h0018, '0, 1'b0, init_word(16'h0018));
        access("f20", 1'b0, 16'h0020, '0, 1'b0, init_word(16'h0020));
        access("f28", 1'b0, 16'h0028, '0, 1'b0, init_word(16'h0028));
        check_eq("fill_txns", 64'(txlog.size()), 64'(3));
        txlog.delete();
        access("ev30", 1'b0, 16'h0030, '0, 1'b0, init_word(16'h0030));
        check_eq("ev_txns", 64'(txlog.size()), 64'(2));
        if (txlog.size() >= 2) begin
            check_eq("ev_wb_wr", 64'(txlog[0].wr), 64'(1));
            check_eq("ev_wb_addr", 64'(txlog[0].a), 64'h0010);
            check_eq("ev_wb_data", txlog[0].d, 64'h4444_3333_BEEF_1111);
            check_eq("ev_fill_wr", 64'(txlog[1].wr), 64'(0));
            check_eq("ev_fill_addr", 64'(txlog[1].a), 64'h0030);
        end

        // LRU ordering: ways 0..3 touched, way 0 again, so way 1 (line 0x18) is the victim
        access("t30", 1'b0, 16'h0030, '0, 1'b1, init_word(16'h0030));
        access("t18", 1'b0, 16'h0018, '0, 1'b1, init_word(16'h0018));
        access("t20", 1'b0, 16'h0020, '0, 1'b1, init_word(16'h0020));
        access("t28", 1'b0, 16'h0028, '0, 1'b1, init_word(16'h0028));
        access("t30b", 1'b0, 16'h0030, '0, 1'b1, init_word(16'h0030));
        txlog.delete();
        access("m38", 1'b0, 16'h0038, '0, 1'b0, init_word(16'h0038));
        check_eq("lru_txns", 64'(txlog.size()), 64'(1));
        access("h30", 1'b0, 16'h0030, '0, 1'b1, init_word(16'h0030));
        access("h20", 1'b0, 16'h0020, '0, 1'b1, init_word(16'h0020));
        access("h28", 1'b0, 16'h0028, '0, 1'b1, init_word(16'h0028));
        access("h38", 1'b0, 16'h0038, '0, 1'b1, init_word(16'h0038));
        access("m18", 1'b0, 16'h0018, '0, 1'b0, init_word(16'h0018));
        check_counts("cnt2");

        // Flush with two dirty lines: set 0 way 2 (0x20), then set 1 way 0 (0x04)
        access("wr21", 1'b1, 16'h0021, 16'hCAFE, 1'b1, '0);
        access("wr04", 1'b1, 16'h0004, 16'h1234, 1'b0, '0);
        txlog.delete();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check_eq("fl_busy", 64'(flush_busy), 64'(1));
        cyc = 0;
        while (flush_busy && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
        check_eq("fl_done", 64'(flush_busy), 64'(0));
        check_eq("fl_txns", 64'(txlog.size()), 64'(2));
        if (txlog.size() >= 2) begin
            check_eq("fl0_addr", 64'(txlog[0].a), 64'h0020);
            check_eq("fl0_data", txlog[0].d, 64'h3008_2008_CAFE_0008);
            check_eq("fl0_busy", 64'(txlog[0].busy), 64'(1));
            check_eq("fl1_addr", 64'(txlog[1].a), 64'h0004);
            check_eq("fl1_data", txlog[1].d, 64'h3001_2001_1001_1234);
            check_eq("fl1_busy", 64'(txlog[1].busy), 64'(1));
        end
        @(posedge clk);
        #1;

        // Everything misses after the flush; make line 0x30 dirty and least recently used
        access("pf30", 1'b0, 16'h0030, '0, 1'b0, init_word(16'h0030));
        access("pf28", 1'b0, 16'h0028, '0, 1'b0, init_word(16'h0028));
        access("pf21", 1'b0, 16'h0021, '0, 1'b0, 16'hCAFE);
        access("pw31", 1'b1, 16'h0031, 16'h5555, 1'b1, '0);
        access("pf18", 1'b0, 16'h0018, '0, 1'b0, init_word(16'h0018));
        access("pt28", 1'b0, 16'h0028, '0, 1'b1, init_word(16'h0028));
        access("pt20", 1'b0, 16'h0020, '0, 1'b1, init_word(16'h0020));
        access("pt18", 1'b0, 16'h0018, '0, 1'b1, init_word(16'h0018));
        check_counts("cnt3");

        // Reset asserted while the write-back is outstanding
        ack_delay = 20;
        read = 1'b1;
        address = 16'h0048;
        cyc = 0;
        @(negedge clk);
        while (!writeM && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        check_eq("wb_writeM", 64'(writeM), 64'(1));
        check_eq("wb_addrM", 64'(addressM), 64'h0030);
        check_eq("wb_dataM", dataM_out, 64'h300C_200C_5555_000C);
        #2;
        reset_n = 1'b0;
        read = 1'b0;
        #1;
        check_eq("ar_writeM", 64'(writeM), 64'(0));
        check_eq("ar_readM", 64'(readM), 64'(0));
        check_eq("ar_hits", 64'(hit_count), 64'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ack_delay = 0;
        exp_hit = 0;
        exp_miss = 0;
        access("ar28", 1'b0, 16'h0028, '0, 1'b0, init_word(16'h0028));
        access("ar31", 1'b0, 16'h0031, '0, 1'b0, 16'h100C);

        // Counter saturation on the 4-bit instance
        for (int i = 0; i < 19; i++) begin
            access("sat", 1'b0, 16'(16'h0028 + (i % 4)), '0, 1'b1,
                   init_word(16'(16'h0028 + (i % 4))));
            if (i == 14) check_eq("sat15_c4", 64'(c4_hit_count), 64'hF);
        end
        check_counts("cnt4");
        check_eq("sat_c4_hits", 64'(c4_hit_count), 64'hF);
        check_eq("sat_c4_misses", 64'(c4_miss_count), 64'(2));
        check_eq("c4_readM", 64'(c4_readM), 64'(0));
        check_eq("c4_writeM", 64'(c4_writeM), 64'(0));
        check_eq("c4_busy", 64'(c4_flush_busy), 64'(0));
        check_eq("c4_addrM", 64'(c4_addressM), 64'h0030);
        check_eq("c4_dataM", c4_dataM_out, 64'(0));
        check_eq("addrM_last", 64'(addressM), 64'h0030);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
